// File: rtl/instruction_decode_stage.sv
// Decode stage of the multi-cycle RV32I core.
// Takes one fetched instruction at a time and drives its source register
// addresses to the register file. It waits out the register file read latency,
// then holds a decoded bundle for execute until the bundle is accepted.
module instruction_decode_stage #(
  parameter int READ_LATENCY = 1,
  parameter bit ZERO_X0      = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  input  logic [31:0] instr_pc,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_rs1_value,
  output logic [31:0] out_rs2_value,
  output logic [4:0]  out_rd,
  output logic [31:0] out_imm,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic        out_illegal
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_VALID   = 2'd3
  } state_t;

  // The wait counter starts at READ_LATENCY-1 so READ lasts exactly READ_LATENCY cycles.
  localparam logic [1:0] WAIT_INIT = 2'(READ_LATENCY - 1);

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  state_t      state_r;
  logic [1:0]  wait_cnt_r;
  logic [31:0] ir_r;
  logic [31:0] pc_r;

  logic [31:0] imm_s;
  logic        illegal_s;
  logic [31:0] rs1_value_s;
  logic [31:0] rs2_value_s;

  // Source addresses come straight from the instruction register. They stay stable
  // from acceptance until the next instruction is latched.
  assign rs1_addr = ir_r[19:15];
  assign rs2_addr = ir_r[24:20];

  // Immediate assembly and legality check, both keyed on the opcode of the held instruction.
  always_comb begin
    imm_s     = 32'd0;
    illegal_s = 1'b0;
    case (ir_r[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        imm_s = {{20{ir_r[31]}}, ir_r[31:20]};
      end
      OP_STORE: begin
        imm_s = {{20{ir_r[31]}}, ir_r[31:25], ir_r[11:7]};
      end
      OP_BRANCH: begin
        imm_s = {{19{ir_r[31]}}, ir_r[31], ir_r[7], ir_r[30:25], ir_r[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        imm_s = {ir_r[31:12], 12'd0};
      end
      OP_JAL: begin
        imm_s = {{11{ir_r[31]}}, ir_r[31], ir_r[19:12], ir_r[20], ir_r[30:21], 1'b0};
      end
      OP_OP, OP_MISC_MEM: begin
        imm_s = 32'd0;
      end
      default: begin
        imm_s     = 32'd0;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Operand selection. x0 reads as zero whatever the register file returns, when enabled.
  always_comb begin
    rs1_value_s = rs1_data;
    rs2_value_s = rs2_data;
    if (ZERO_X0 && (ir_r[19:15] == 5'd0)) begin
      rs1_value_s = 32'd0;
    end else begin
      rs1_value_s = rs1_data;
    end
    if (ZERO_X0 && (ir_r[24:20] == 5'd0)) begin
      rs2_value_s = 32'd0;
    end else begin
      rs2_value_s = rs2_data;
    end
  end

  // Control FSM with registered handshakes and bundle: IDLE -> READ -> CAPTURE -> VALID.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= 2'd0;
      ir_r          <= 32'd0;
      pc_r          <= 32'd0;
      instr_ready   <= 1'b1;
      out_valid     <= 1'b0;
      out_pc        <= 32'd0;
      out_rs1_value <= 32'd0;
      out_rs2_value <= 32'd0;
      out_rd        <= 5'd0;
      out_imm       <= 32'd0;
      out_opcode    <= 7'd0;
      out_funct3    <= 3'd0;
      out_funct7    <= 7'd0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      // Redirect: drop whatever is in flight and be ready again next cycle.
      state_r     <= ST_IDLE;
      instr_ready <= 1'b1;
      out_valid   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (instr_valid && instr_ready) begin
            ir_r        <= instruction;
            pc_r        <= instr_pc;
            wait_cnt_r  <= WAIT_INIT;
            instr_ready <= 1'b0;
            state_r     <= ST_READ;
          end else begin
            instr_ready <= 1'b1;
          end
        end
        ST_READ: begin
          if (wait_cnt_r == 2'd0) begin
            state_r <= ST_CAPTURE;
          end else begin
            wait_cnt_r <= wait_cnt_r - 2'd1;
          end
        end
        ST_CAPTURE: begin
          out_pc        <= pc_r;
          out_rs1_value <= rs1_value_s;
          out_rs2_value <= rs2_value_s;
          out_rd        <= ir_r[11:7];
          out_imm       <= imm_s;
          out_opcode    <= ir_r[6:0];
          out_funct3    <= ir_r[14:12];
          out_funct7    <= ir_r[31:25];
          out_illegal   <= illegal_s;
          out_valid     <= 1'b1;
          state_r       <= ST_VALID;
        end
        ST_VALID: begin
          // instr_ready rises only after the handoff edge, so no same-cycle accept.
          if (out_ready) begin
            out_valid   <= 1'b0;
            instr_ready <= 1'b1;
            state_r     <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          instr_ready <= 1'b1;
          out_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule
